// File: rtl/debug_port_master.sv
`timescale 1ns/1ps
// Debug-port burst master: moves word bursts between a host handshake and the
// instruction/data RAM debug ports. Define DBG_PORT_VERIFY_EN for write readback verification.
module debug_port_master #(
  parameter int RD_LATENCY = 1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_sel,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic [31:0] dbg_inst_a2,
  output logic [31:0] dbg_inst_wd2,
  output logic [3:0]  dbg_inst_we2,
  input  logic [31:0] dbg_inst_rd2,
  output logic [31:0] dbg_data_a2,
  output logic [31:0] dbg_data_wd2,
  output logic [3:0]  dbg_data_we2,
  input  logic [31:0] dbg_data_rd2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        verify_fail,
  output logic [31:0] fail_addr
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE
`ifdef DBG_PORT_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t      state_q;
  logic        sel_q;
  logic [31:0] addr_q;
  logic [31:0] addr_d;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [1:0]  wait_q;
  logic        mis_q;
  logic [31:0] rd_data_q;
  logic        done_q;
  logic        err_q;

  logic        wr_beat;
  logic        rd_phase;
  logic [31:0] port_a2;
  logic [31:0] port_wd2;
  logic [3:0]  port_we2;
  logic [31:0] rd2_sel;

  assign addr_d   = addr_q + 32'd4;
  assign wr_beat  = (state_q == S_WRITE) && wr_valid;
`ifdef DBG_PORT_VERIFY_EN
  assign rd_phase = (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT) || (state_q == S_VERIFY);
`else
  assign rd_phase = (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT);
`endif

  // Port strobes are combinational from the write handshake so each beat is exactly one cycle.
  assign port_a2  = (wr_beat || rd_phase) ? addr_q : 32'd0;
  assign port_wd2 = wr_beat ? wr_data : 32'd0;
  assign port_we2 = wr_beat ? 4'hF : 4'h0;
  assign rd2_sel  = sel_q ? dbg_inst_rd2 : dbg_data_rd2;

  always_comb begin
    dbg_inst_a2  = 32'd0;
    dbg_inst_wd2 = 32'd0;
    dbg_inst_we2 = 4'h0;
    dbg_data_a2  = 32'd0;
    dbg_data_wd2 = 32'd0;
    dbg_data_we2 = 4'h0;
    if (sel_q) begin
      dbg_inst_a2  = port_a2;
      dbg_inst_wd2 = port_wd2;
      dbg_inst_we2 = port_we2;
    end else begin
      dbg_data_a2  = port_a2;
      dbg_data_wd2 = port_wd2;
      dbg_data_we2 = port_we2;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !CPU_RST;
  assign wr_ready  = (state_q == S_WRITE);
  assign rd_valid  = (state_q == S_RD_OUT);
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

`ifdef DBG_PORT_VERIFY_EN
  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  logic [31:0] start_q;
  logic        vfail_q;
  logic [31:0] faddr_q;
  logic [31:0] shadow_q [256];

  // Shadow of the burst's write data, indexed by beat number.
  always_ff @(posedge CPU_CLK) begin
    if (wr_beat) shadow_q[cnt_q] <= wr_data;
  end

  assign verify_fail = vfail_q;
  assign fail_addr   = faddr_q;
`else
  assign verify_fail = 1'b0;
  assign fail_addr   = 32'd0;
`endif

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      wait_q    <= 2'd0;
      mis_q     <= 1'b0;
      rd_data_q <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef DBG_PORT_VERIFY_EN
      start_q   <= 32'd0;
      vfail_q   <= 1'b0;
      faddr_q   <= 32'd0;
`endif
    end else begin
      // done/err are registered one cycle behind the DONE state.
      done_q <= (state_q == S_DONE);
      err_q  <= (state_q == S_DONE) && mis_q;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            sel_q  <= cmd_sel;
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            cnt_q  <= 8'd0;
            wait_q <= 2'd0;
            mis_q  <= (cmd_addr[1:0] != 2'b00);
`ifdef DBG_PORT_VERIFY_EN
            start_q <= cmd_addr;
            vfail_q <= 1'b0;
            faddr_q <= 32'd0;
`endif
            if (cmd_addr[1:0] != 2'b00) state_q <= S_DONE;
            else if (cmd_write)         state_q <= S_WRITE;
            else                        state_q <= S_RD_ISSUE;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            addr_q <= addr_d;
            if (cnt_q == len_q) begin
              cnt_q <= 8'd0;
`ifdef DBG_PORT_VERIFY_EN
              addr_q  <= start_q;
              wait_q  <= 2'd0;
              state_q <= S_VERIFY;
`else
              state_q <= S_DONE;
`endif
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_RD_ISSUE: begin
          wait_q  <= 2'd0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (wait_q == LAT_M1) begin
            rd_data_q <= rd2_sel;
            state_q   <= S_RD_OUT;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        S_RD_OUT: begin
          if (rd_ready) begin
            addr_q <= addr_d;
            if (cnt_q == len_q) begin
              state_q <= S_DONE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              state_q <= S_RD_ISSUE;
            end
          end
        end
`ifdef DBG_PORT_VERIFY_EN
        S_VERIFY: begin
          // Address is held LAT+1 cycles so RD2 at the compare cycle belongs to it.
          if (wait_q == LAT) begin
            wait_q <= 2'd0;
            addr_q <= addr_d;
            if ((rd2_sel != shadow_q[cnt_q]) && !vfail_q) begin
              vfail_q <= 1'b1;
              faddr_q <= addr_q;
            end
            if (cnt_q == len_q) state_q <= S_DONE;
            else                cnt_q   <= cnt_q + 8'd1;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_port_master.sv
`timescale 1ns/1ps
// Scoreboard bench for debug_port_master: directed bursts against two latency-modelled debug RAMs.
module tb_debug_port_master;
  localparam int RD_LAT = 2;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_sel;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [31:0] wr_data, rd_data;
  logic [31:0] dbg_inst_a2, dbg_inst_wd2, dbg_inst_rd2;
  logic [3:0]  dbg_inst_we2;
  logic [31:0] dbg_data_a2, dbg_data_wd2, dbg_data_rd2;
  logic [3:0]  dbg_data_we2;
  logic        busy, done, err, verify_fail;
  logic [31:0] fail_addr;

  debug_port_master #(.RD_LATENCY(RD_LAT)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .dbg_inst_a2(dbg_inst_a2), .dbg_inst_wd2(dbg_inst_wd2), .dbg_inst_we2(dbg_inst_we2),
    .dbg_inst_rd2(dbg_inst_rd2),
    .dbg_data_a2(dbg_data_a2), .dbg_data_wd2(dbg_data_wd2), .dbg_data_we2(dbg_data_we2),
    .dbg_data_rd2(dbg_data_rd2),
    .busy(busy), .done(done), .err(err), .verify_fail(verify_fail), .fail_addr(fail_addr)
  );

  always #5 CPU_CLK = ~CPU_CLK;

`ifdef DBG_PORT_VERIFY_EN
  localparam bit VF_EN = 1'b1;
`else
  localparam bit VF_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit mon_en = 1'b0;
  bit exp_sel = 1'b0;
  bit corrupt = 1'b0;

  always @(posedge CPU_CLK) cyc <= cyc + 1;

  // RAM models: RD2 reflects the address presented RD_LAT cycles earlier; word at 0x208 can be corrupted.
  logic [31:0] imem [1024] = '{default: '0};
  logic [31:0] dmem [1024] = '{default: '0};
  logic [31:0] ipipe [RD_LAT] = '{default: '0};
  logic [31:0] dpipe [RD_LAT] = '{default: '0};

  always @(posedge CPU_CLK) begin
    ipipe[0] <= dbg_inst_a2;
    dpipe[0] <= dbg_data_a2;
    for (int i = 1; i < RD_LAT; i++) begin
      ipipe[i] <= ipipe[i-1];
      dpipe[i] <= dpipe[i-1];
    end
    if (dbg_inst_we2 == 4'hF)
      imem[dbg_inst_a2[11:2]] <= dbg_inst_wd2 ^ ((corrupt && dbg_inst_a2 == 32'h208) ? 32'h1 : 32'h0);
    if (dbg_data_we2 == 4'hF)
      dmem[dbg_data_a2[11:2]] <= dbg_data_wd2 ^ ((corrupt && dbg_data_a2 == 32'h208) ? 32'h1 : 32'h0);
  end

  assign dbg_inst_rd2 = imem[ipipe[RD_LAT-1][11:2]];
  assign dbg_data_rd2 = dmem[dpipe[RD_LAT-1][11:2]];

  typedef struct {
    int          kind;   // 0 write beat, 1 read word, 2 done
    bit          port;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    bit          vf;
    logic [31:0] fa;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_wr(input bit port, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e = '{kind: 0, port: port, addr: a, data: d, err: 1'b0, vf: 1'b0, fa: 32'd0, lat: -1};
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] d);
    exp_t e;
    e = '{kind: 1, port: 1'b0, addr: 32'd0, data: d, err: 1'b0, vf: 1'b0, fa: 32'd0, lat: -1};
    exp_q.push_back(e);
  endtask

  task automatic push_done(input bit e_err, input bit e_vf, input logic [31:0] e_fa, input int lat);
    exp_t e;
    e = '{kind: 2, port: 1'b0, addr: 32'd0, data: 32'd0, err: e_err, vf: e_vf, fa: e_fa, lat: lat};
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge and pops the scoreboard whenever the DUT presents an event.
  always @(negedge CPU_CLK) begin
    exp_t e;
    bit   wport;
    if (mon_en) begin
      check("no_x_outputs", 32'($isunknown({cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
            verify_fail, fail_addr, dbg_inst_a2, dbg_inst_wd2, dbg_inst_we2,
            dbg_data_a2, dbg_data_wd2, dbg_data_we2})), 32'd0);
      if (exp_sel) check("data_port_idle", dbg_data_a2 | dbg_data_wd2 | 32'(dbg_data_we2), 32'd0);
      else         check("inst_port_idle", dbg_inst_a2 | dbg_inst_wd2 | 32'(dbg_inst_we2), 32'd0);
      check("wd2_zero_without_we",
            ((dbg_inst_we2 == 4'h0) ? dbg_inst_wd2 : 32'd0) | ((dbg_data_we2 == 4'h0) ? dbg_data_wd2 : 32'd0),
            32'd0);
      if (dbg_inst_we2 != 4'h0 || dbg_data_we2 != 4'h0) begin
        wport = (dbg_inst_we2 != 4'h0);
        if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write",
                   wport ? dbg_inst_a2 : dbg_data_a2, wport ? dbg_inst_wd2 : dbg_data_wd2);
        end else begin
          e = exp_q.pop_front();
          check("wr_port", 32'(wport), 32'(e.port));
          check("wr_addr", wport ? dbg_inst_a2 : dbg_data_a2, e.addr);
          check("wr_data", wport ? dbg_inst_wd2 : dbg_data_wd2, e.data);
          check("wr_we2", 32'(wport ? dbg_inst_we2 : dbg_data_we2), 32'hF);
        end
      end
      if (rd_valid) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
          tests++; fails++;
          $display("FAIL unexpected_rd_valid: got rd_data %h, required rd_valid low", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q[0].data);
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 err=%0b, required no done", err);
        end else begin
          e = exp_q.pop_front();
          check("done_err", 32'(err), 32'(e.err));
          check("done_verify_fail", 32'(verify_fail), 32'(e.vf));
          check("done_fail_addr", fail_addr, e.fa);
          if (e.lat >= 0) check("done_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic step();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic issue(input bit wr, input bit sel, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    while (!cmd_ready && n < 200) begin step(); n++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=0, required 1 within 200 cycles");
    end
    exp_sel   = sel;
    cmd_write = wr;
    cmd_sel   = sel;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    acc_cyc   = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    while (!wr_ready && n < 200) begin step(); n++; end
    if (!wr_ready) begin
      tests++; fails++;
      $display("FAIL wr_ready_timeout: got wr_ready=0, required 1 within 200 cycles");
    end
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    wr_data  = 32'd0;
  endtask

  task automatic recv_word(input int hold);
    int n = 0;
    while (!rd_valid && n < 200) begin step(); n++; end
    if (!rd_valid) begin
      tests++; fails++;
      $display("FAIL rd_valid_timeout: got rd_valid=0, required 1 within 200 cycles");
    end
    rd_ready = 1'b0;
    repeat (hold) step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin step(); n++; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish within 300000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
    wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0;
    #2 CPU_RST = 1'b1;
    mon_en = 1'b1;
    step(); step();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_verify_fail", 32'(verify_fail), 32'd0);
    check("rst_fail_addr", fail_addr, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_we2", 32'({dbg_inst_we2, dbg_data_we2}), 32'd0);
    CPU_RST = 1'b0;
    #1 check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    step();

    // Instruction-port write burst with a stall before the third word
    push_wr(1'b1, 32'h100, 32'h11); push_wr(1'b1, 32'h104, 32'h22);
    push_wr(1'b1, 32'h108, 32'h33); push_wr(1'b1, 32'h10C, 32'h44);
    push_done(1'b0, 1'b0, 32'd0, -1);
    issue(1'b1, 1'b1, 32'h100, 8'd3);
    check("busy_during_burst", 32'(busy), 32'd1);
    send_word(32'h11); send_word(32'h22);
    step(); step();
    send_word(32'h33); send_word(32'h44);
    wait_idle();

    // Data-port write then read-back with rd_ready held low on word 0
    push_wr(1'b0, 32'h40, 32'hDEADBEEF); push_wr(1'b0, 32'h44, 32'hCAFEF00D);
    push_done(1'b0, 1'b0, 32'd0, -1);
    issue(1'b1, 1'b0, 32'h40, 8'd1);
    send_word(32'hDEADBEEF); send_word(32'hCAFEF00D);
    wait_idle();
    push_rd(32'hDEADBEEF); push_rd(32'hCAFEF00D);
    push_done(1'b0, 1'b0, 32'd0, -1);
    issue(1'b0, 1'b0, 32'h40, 8'd1);
    recv_word(5); recv_word(0);
    wait_idle();

    // Misaligned command: done with err two cycles after acceptance, no port activity
    push_done(1'b1, 1'b0, 32'd0, 2);
    issue(1'b1, 1'b1, 32'h102, 8'd3);
    wait_idle();

    // Address wrap at the top of the space, for write and read
    push_wr(1'b1, 32'hFFFF_FFFC, 32'h5A5A0001); push_wr(1'b1, 32'h0, 32'h5A5A0002);
    push_done(1'b0, 1'b0, 32'd0, -1);
    issue(1'b1, 1'b1, 32'hFFFF_FFFC, 8'd1);
    send_word(32'h5A5A0001); send_word(32'h5A5A0002);
    wait_idle();
    push_rd(32'h5A5A0001); push_rd(32'h5A5A0002);
    push_done(1'b0, 1'b0, 32'd0, -1);
    issue(1'b0, 1'b1, 32'hFFFF_FFFC, 8'd1);
    recv_word(0); recv_word(0);
    wait_idle();

    // Reset mid-burst after the third word of an 8-word write
    push_wr(1'b1, 32'h300, 32'hA1); push_wr(1'b1, 32'h304, 32'hA2); push_wr(1'b1, 32'h308, 32'hA3);
    issue(1'b1, 1'b1, 32'h300, 8'd7);
    send_word(32'hA1); send_word(32'hA2); send_word(32'hA3);
    wr_valid = 1'b1;
    wr_data  = 32'hBAD;
    CPU_RST  = 1'b1;
    #1;
    check("abort_we2_immediate", 32'(dbg_inst_we2), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    check("abort_beats_seen", 32'(exp_q.size()), 32'd0);
    wr_valid = 1'b0;
    wr_data  = 32'd0;
    step(); step();
    CPU_RST = 1'b0;
    #1 check("abort_cmd_ready_release", 32'(cmd_ready), 32'd1);
    repeat (10) step();

    // Next command runs normally: read back the first burst
    push_rd(32'h11); push_rd(32'h22); push_rd(32'h33); push_rd(32'h44);
    push_done(1'b0, 1'b0, 32'd0, -1);
    issue(1'b0, 1'b1, 32'h100, 8'd3);
    recv_word(0); recv_word(1); recv_word(0); recv_word(2);
    wait_idle();

    // Readback verification with the RAM corrupting the word at 0x208
    corrupt = 1'b1;
    push_wr(1'b0, 32'h200, 32'hA0); push_wr(1'b0, 32'h204, 32'hA1);
    push_wr(1'b0, 32'h208, 32'hA2); push_wr(1'b0, 32'h20C, 32'hA3);
    push_done(1'b0, VF_EN, VF_EN ? 32'h208 : 32'h0, -1);
    issue(1'b1, 1'b0, 32'h200, 8'd3);
    send_word(32'hA0); send_word(32'hA1); send_word(32'hA2); send_word(32'hA3);
    wait_idle();
    corrupt = 1'b0;
    check("verify_fail_sticky", 32'(verify_fail), 32'(VF_EN));

    // A new command clears the verification flags
    push_rd(32'hA0);
    push_done(1'b0, 1'b0, 32'd0, -1);
    issue(1'b0, 1'b0, 32'h200, 8'd0);
    recv_word(0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
